rom_boot_copier: RTL and testbench



---
 rtl/rom_boot_copier.sv | 121 ++++++++++++
 tb/tb_rom_boot_copier.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_boot_copier.sv
// Copies n_words words from a registered-output boot ROM to dest_base.. over a Wishbone classic master.
// Latency: 3 cycles per word plus slave wait states, plus one DONE cycle; backpressure comes only from slave ack/err.
module rom_boot_copier #(
    parameter int          aw        = 5,
    parameter int          n_words   = 2**aw,
    parameter logic [31:0] dest_base = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          rom_en,
    output logic [aw-1:0] rom_adr,
    input  logic [31:0]   rom_dat,
    output logic [31:0]   wbm_adr_o,
    output logic [31:0]   wbm_dat_o,
    output logic [3:0]    wbm_sel_o,
    output logic          wbm_we_o,
    output logic          wbm_cyc_o,
    output logic          wbm_stb_o,
    input  logic          wbm_ack_i,
    input  logic          wbm_err_i
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [aw:0] last_idx = (aw+1)'(n_words - 1);

    state_t        state_q, state_d;
    logic [aw:0]   idx_q, idx_d;
    logic [31:0]   dat_q, dat_d;
    logic          err_q, err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            dat_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dat_q   <= dat_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dat_d   = dat_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    idx_d   = '0;
                    err_d   = 1'b0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_LATCH;
            S_LATCH: begin
                // ROM output register holds the word addressed in FETCH
                dat_d   = rom_dat;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (wbm_err_i) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (wbm_ack_i) begin
                    if (idx_q == last_idx) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + (aw+1)'(1);
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decode from state so an async reset silences the bus at once
    always_comb begin
        busy      = (state_q != S_IDLE);
        done      = 1'b0;
        err       = err_q;
        rom_en    = 1'b0;
        rom_adr   = '0;
        wbm_adr_o = '0;
        wbm_dat_o = '0;
        wbm_sel_o = 4'hF;
        wbm_we_o  = 1'b0;
        wbm_cyc_o = 1'b0;
        wbm_stb_o = 1'b0;
        case (state_q)
            S_FETCH: begin
                rom_en  = 1'b1;
                rom_adr = idx_q[aw-1:0];
            end
            S_WRITE: begin
                wbm_adr_o = dest_base + (32'(idx_q) << 2);
                wbm_dat_o = dat_q;
                wbm_we_o  = 1'b1;
                wbm_cyc_o = 1'b1;
                wbm_stb_o = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_rom_boot_copier.sv
// Bench for rom_boot_copier: ROM and Wishbone slave models, expectations from a word-list/latency model.
module tb_rom_boot_copier;
    localparam int          AW   = 3;
    localparam int          NW   = 8;
    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam logic [31:0] NOERR = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // instance A: 8-word copy
    logic a_start = 1'b0, a_busy, a_done, a_err, a_rom_en;
    logic [AW-1:0] a_rom_adr;
    logic [31:0] a_rom_dat = '0, a_adr, a_dat;
    logic [3:0] a_sel;
    logic a_we, a_cyc, a_stb, a_ack, a_berr, a_term;
    // instance B: single-word copy
    logic b_start = 1'b0, b_busy, b_done, b_err, b_rom_en;
    logic [AW-1:0] b_rom_adr;
    logic [31:0] b_rom_dat = '0, b_adr, b_dat;
    logic [3:0] b_sel;
    logic b_we, b_cyc, b_stb, b_ack, b_berr;

    rom_boot_copier #(.aw(AW), .n_words(NW), .dest_base(BASE)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(a_start), .busy(a_busy), .done(a_done), .err(a_err),
        .rom_en(a_rom_en), .rom_adr(a_rom_adr), .rom_dat(a_rom_dat),
        .wbm_adr_o(a_adr), .wbm_dat_o(a_dat), .wbm_sel_o(a_sel), .wbm_we_o(a_we),
        .wbm_cyc_o(a_cyc), .wbm_stb_o(a_stb), .wbm_ack_i(a_ack), .wbm_err_i(a_berr));

    rom_boot_copier #(.aw(AW), .n_words(1), .dest_base(BASE)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(b_start), .busy(b_busy), .done(b_done), .err(b_err),
        .rom_en(b_rom_en), .rom_adr(b_rom_adr), .rom_dat(b_rom_dat),
        .wbm_adr_o(b_adr), .wbm_dat_o(b_dat), .wbm_sel_o(b_sel), .wbm_we_o(b_we),
        .wbm_cyc_o(b_cyc), .wbm_stb_o(b_stb), .wbm_ack_i(b_ack), .wbm_err_i(b_berr));

    logic [31:0] rom_mem [NW];
    always @(posedge clk) begin
        if (a_rom_en) a_rom_dat <= rom_mem[a_rom_adr];
        if (b_rom_en) b_rom_dat <= rom_mem[b_rom_adr];
    end

    // slave A: fixed wait states per run, error response on one chosen address
    int a_wait = 0;
    int a_cnt = 0;
    logic [31:0] a_err_adr = NOERR;
    assign a_term = a_cyc && a_stb && (a_cnt == a_wait);
    assign a_berr = a_term && (a_adr == a_err_adr);
    assign a_ack  = a_term && !a_berr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) a_cnt <= 0;
        else if (!a_stb || a_term) a_cnt <= 0;
        else a_cnt <= a_cnt + 1;
    end
    assign b_ack  = b_cyc && b_stb;
    assign b_berr = 1'b0;

    int vectors = 0, miscompares = 0;
    int mcyc = 0, wcount = 0, done_count = 0, last_done = 0, stab_errs = 0;
    logic [31:0] wr_adr [256];
    logic [31:0] wr_dat [256];
    logic [3:0]  wr_sel [256];
    logic [31:0] prev_adr = '0, prev_dat = '0;
    int b_wcount = 0, b_done_count = 0;
    int b_done_cyc [16];
    logic [31:0] b_wr_adr [16];
    logic [31:0] b_wr_dat [16];

    // mid-cycle monitor: records completed writes, done pulses and bus stability
    always @(negedge clk) begin
        mcyc = mcyc + 1;
        if (a_ack && wcount < 256) begin
            wr_adr[wcount] = a_adr; wr_dat[wcount] = a_dat; wr_sel[wcount] = a_sel;
            wcount = wcount + 1;
        end
        if (a_stb && a_cnt > 0 && (a_adr !== prev_adr || a_dat !== prev_dat)) stab_errs = stab_errs + 1;
        prev_adr = a_adr; prev_dat = a_dat;
        if (a_done) begin done_count = done_count + 1; last_done = mcyc; end
        if (b_ack && b_wcount < 16) begin
            b_wr_adr[b_wcount] = b_adr; b_wr_dat[b_wcount] = b_dat; b_wcount = b_wcount + 1;
        end
        if (b_done && b_done_count < 16) begin b_done_cyc[b_done_count] = mcyc; b_done_count = b_done_count + 1; end
    end

    // reference model: words written before the first error address, and run length
    function automatic int model_words(input logic [31:0] eadr);
        for (int i = 0; i < NW; i++) if (BASE + 32'(4 * i) == eadr) return i;
        return NW;
    endfunction
    function automatic int model_latency(input int wait_n, input logic [31:0] eadr);
        int beats;
        beats = (model_words(eadr) < NW) ? model_words(eadr) + 1 : NW;
        return beats * (3 + wait_n) + 1;
    endfunction

    task automatic do_run(input int wait_n, input logic [31:0] eadr, output int lat, output int w0, output bit tmo);
        int t0, d0;
        a_wait = wait_n; a_err_adr = eadr; w0 = wcount; d0 = done_count;
        @(negedge clk); #1 a_start = 1'b1; t0 = mcyc;
        @(negedge clk); #1 a_start = 1'b0;
        tmo = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            if (done_count != d0) begin tmo = 1'b0; break; end
            @(negedge clk); #1;
        end
        lat = last_done - t0;
    endtask

    task automatic test_reset;
        #12;
        vectors++;
        if ({a_busy, a_done, a_err, a_rom_en, a_cyc, a_stb, a_we} !== 7'b0 || a_adr !== 32'h0 ||
            a_dat !== 32'h0 || a_rom_adr !== 3'd0 || a_sel !== 4'hF) begin
            miscompares++;
            $display("FAIL reset_state: ctl %b adr %h dat %h rom_adr %0d sel %h, want ctl 0 adr 0 dat 0 rom_adr 0 sel f",
                     {a_busy, a_done, a_err, a_rom_en, a_cyc, a_stb, a_we}, a_adr, a_dat, a_rom_adr, a_sel);
        end
        @(negedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_basic;
        int lat, w0; bit tmo;
        for (int i = 0; i < NW; i++) rom_mem[i] = 32'hA5A5_0000 + 32'(i);
        do_run(0, NOERR, lat, w0, tmo);
        vectors++;
        if (tmo || lat != 25 || wcount - w0 != NW || a_err !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_run: timeout %0d latency %0d writes %0d err %b, want timeout 0 latency 25 writes 8 err 0",
                     tmo, lat, wcount - w0, a_err);
        end
        for (int i = 0; i < NW; i++) begin
            vectors++;
            if (wr_adr[w0+i] !== BASE + 32'(4*i) || wr_dat[w0+i] !== rom_mem[i] || wr_sel[w0+i] !== 4'hF) begin
                miscompares++;
                $display("FAIL basic_write[%0d]: adr %h dat %h sel %h, want adr %h dat %h sel f",
                         i, wr_adr[w0+i], wr_dat[w0+i], wr_sel[w0+i], BASE + 32'(4*i), rom_mem[i]);
            end
        end
    endtask

    task automatic test_wait_states;
        int lat, w0, s0; bit tmo;
        s0 = stab_errs;
        do_run(3, NOERR, lat, w0, tmo);
        vectors++;
        if (tmo || lat != 8 * 6 + 1 || wcount - w0 != NW || stab_errs != s0) begin
            miscompares++;
            $display("FAIL wait_run: timeout %0d latency %0d writes %0d unstable %0d, want timeout 0 latency 49 writes 8 unstable 0",
                     tmo, lat, wcount - w0, stab_errs - s0);
        end
        for (int i = 0; i < NW; i++) begin
            vectors++;
            if (wr_adr[w0+i] !== BASE + 32'(4*i) || wr_dat[w0+i] !== 32'hA5A5_0000 + 32'(i)) begin
                miscompares++;
                $display("FAIL wait_write[%0d]: adr %h dat %h, want adr %h dat %h",
                         i, wr_adr[w0+i], wr_dat[w0+i], BASE + 32'(4*i), 32'hA5A5_0000 + 32'(i));
            end
        end
    endtask

    task automatic test_random;
        int lat, w0, wn, nexp; bit tmo; logic [31:0] eadr;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NW; i++) rom_mem[i] = $urandom;
            wn = $urandom_range(0, 4);
            eadr = ($urandom_range(0, 2) == 0) ? BASE + 32'(4 * $urandom_range(0, NW-1)) : NOERR;
            nexp = model_words(eadr);
            do_run(wn, eadr, lat, w0, tmo);
            vectors++;
            if (tmo || lat != model_latency(wn, eadr) || wcount - w0 != nexp || a_err !== (nexp < NW)) begin
                miscompares++;
                $display("FAIL random_run[%0d]: timeout %0d latency %0d writes %0d err %b, want latency %0d writes %0d err %b",
                         r, tmo, lat, wcount - w0, a_err, model_latency(wn, eadr), nexp, nexp < NW);
            end
            for (int i = 0; i < nexp; i++) begin
                vectors++;
                if (wr_adr[w0+i] !== BASE + 32'(4*i) || wr_dat[w0+i] !== rom_mem[i]) begin
                    miscompares++;
                    $display("FAIL random_write[%0d][%0d]: adr %h dat %h, want adr %h dat %h",
                             r, i, wr_adr[w0+i], wr_dat[w0+i], BASE + 32'(4*i), rom_mem[i]);
                end
            end
        end
    endtask

    task automatic test_bus_error;
        int lat, w0, d0; bit tmo;
        do_run($urandom_range(0, 2), BASE + 32'h8, lat, w0, tmo);
        repeat (4) @(negedge clk);
        #1;
        vectors++;
        if (tmo || wcount - w0 != 2 || a_err !== 1'b1 || a_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL bus_error: timeout %0d writes %0d err %b busy %b, want timeout 0 writes 2 err 1 busy 0",
                     tmo, wcount - w0, a_err, a_busy);
        end
        a_err_adr = NOERR; d0 = done_count;
        a_start = 1'b1;
        @(negedge clk); #1 a_start = 1'b0;
        vectors++;
        if (a_err !== 1'b0 || a_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL err_clear: err %b busy %b, want err 0 busy 1", a_err, a_busy);
        end
        for (int k = 0; k < 500 && done_count == d0; k++) begin @(negedge clk); #1; end
        vectors++;
        if (done_count == d0 || a_err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_clear_run: done %0d err %b, want done 1 err 0", done_count - d0, a_err);
        end
    endtask

    task automatic test_ignored_start;
        int w0, d0, wn; bit seen;
        wn = $urandom_range(0, 3);
        a_wait = wn; a_err_adr = NOERR; w0 = wcount; d0 = done_count; seen = 1'b0;
        @(negedge clk); #1 a_start = 1'b1;
        @(negedge clk); #1 a_start = 1'b0;
        for (int k = 0; k < 500; k++) begin
            if (a_stb && a_adr == BASE + 32'hC) begin seen = 1'b1; break; end
            @(negedge clk); #1;
        end
        a_start = 1'b1;
        @(negedge clk); #1 a_start = 1'b0;
        for (int k = 0; k < 500 && done_count == d0; k++) begin @(negedge clk); #1; end
        repeat (12) @(negedge clk);
        #1;
        vectors++;
        if (!seen || wcount - w0 != NW || done_count - d0 != 1 || a_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL ignored_start: word4_seen %0d writes %0d done_pulses %0d busy %b, want 1 8 1 0",
                     seen, wcount - w0, done_count - d0, a_busy);
        end
    endtask

    task automatic test_reset_midrun;
        int lat, w0; bit tmo, seen;
        a_wait = 3; a_err_adr = NOERR; seen = 1'b0;
        @(negedge clk); #1 a_start = 1'b1;
        @(negedge clk); #1 a_start = 1'b0;
        repeat (4) @(negedge clk);
        for (int k = 0; k < 200; k++) begin
            #1;
            if (a_stb) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (!seen || {a_busy, a_done, a_err, a_rom_en, a_cyc, a_stb, a_we} !== 7'b0 ||
            a_adr !== 32'h0 || a_dat !== 32'h0 || a_rom_adr !== 3'd0 || a_sel !== 4'hF) begin
            miscompares++;
            $display("FAIL async_reset: stb_seen %0d ctl %b adr %h dat %h sel %h, want stb_seen 1 ctl 0 adr 0 dat 0 sel f",
                     seen, {a_busy, a_done, a_err, a_rom_en, a_cyc, a_stb, a_we}, a_adr, a_dat, a_sel);
        end
        @(negedge clk); #1 rst_n = 1'b1;
        @(negedge clk); #1;
        vectors++;
        if (a_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_busy: busy %b, want 0", a_busy);
        end
        do_run(0, NOERR, lat, w0, tmo);
        vectors++;
        if (tmo || lat != 25 || wcount - w0 != NW || wr_adr[w0] !== BASE || wr_dat[w0] !== rom_mem[0]) begin
            miscompares++;
            $display("FAIL post_reset_run: timeout %0d latency %0d writes %0d first adr %h dat %h, want 0 25 8 %h %h",
                     tmo, lat, wcount - w0, wr_adr[w0], wr_dat[w0], BASE, rom_mem[0]);
        end
    endtask

    task automatic test_back_to_back;
        int w0, d0; bit got;
        rom_mem[0] = $urandom;
        w0 = b_wcount; d0 = b_done_count; got = 1'b0;
        @(negedge clk); #1 b_start = 1'b1;
        @(negedge clk); #1 b_start = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (b_done) begin got = 1'b1; break; end
            @(negedge clk); #1;
        end
        @(negedge clk); #1 b_start = 1'b1;
        @(negedge clk); #1 b_start = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        vectors++;
        if (!got || b_done_count - d0 != 2 || b_wcount - w0 != 2) begin
            miscompares++;
            $display("FAIL b2b_count: first_done %0d done_pulses %0d writes %0d, want 1 2 2",
                     got, b_done_count - d0, b_wcount - w0);
        end else begin
            vectors++;
            if (b_done_cyc[d0+1] - b_done_cyc[d0] != 5) begin
                miscompares++;
                $display("FAIL b2b_spacing: %0d cycles, want 5", b_done_cyc[d0+1] - b_done_cyc[d0]);
            end
            for (int i = 0; i < 2; i++) begin
                vectors++;
                if (b_wr_adr[w0+i] !== BASE || b_wr_dat[w0+i] !== rom_mem[0]) begin
                    miscompares++;
                    $display("FAIL b2b_write[%0d]: adr %h dat %h, want adr %h dat %h",
                             i, b_wr_adr[w0+i], b_wr_dat[w0+i], BASE, rom_mem[0]);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < NW; i++) rom_mem[i] = '0;
        test_reset;
        test_basic;
        test_wait_states;
        test_random;
        test_bus_error;
        test_ignored_start;
        test_reset_midrun;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", miscompares);
        $fatal(1);
    end
endmodule
